// File: rtl/keypad_digit_loader_if.sv
// Keypad loader bus: raw key lines and entry controls in, digit and strobe out.
// The testbench drives the master side; the loader implements the slave side.
interface keypad_digit_loader_if;
  logic [9:0] keypad;
  logic       accept;
  logic       clr_entry;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       busy;

  modport master (
    output keypad, accept, clr_entry,
    input  data, loadn, digit_count, busy
  );

  modport slave (
    input  keypad, accept, clr_entry,
    output data, loadn, digit_count, busy
  );
endinterface

// File: rtl/keypad_digit_loader.sv
// Keypad digit loader for the microwave timer.
// Synchronises and debounces a 10-key decimal keypad. Each accepted keypress
// presents its BCD digit on data and pulses loadn low for one clk cycle.
// digit_count tracks the digits entered since the last clear, saturating at 3.
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input logic              clk,
  input logic              clrn,
  keypad_digit_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    LOAD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [9:0]       ks_meta;
  logic [9:0]       ks;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [9:0]       key_reg, key_next;
  logic [3:0]       data_q;
  logic             loadn_q;
  logic             busy_q;
  logic [1:0]       digit_count_q;
  logic             single_key;

  // Map a one-hot key vector to its BCD digit.
  function automatic logic [3:0] encode(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  // Exactly one key line high: non-zero and a power of two.
  assign single_key = (ks != 10'd0) && ((ks & (ks - 10'd1)) == 10'd0);

  // Two-flop synchroniser for the asynchronous key lines.
  // NOTE: every flop here is reset asynchronously so a reset mid-operation
  // clears the design immediately; the design has no memory arrays.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ks_meta <= 10'd0;
      ks      <= 10'd0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous value
      // of its neighbour, which is what makes this a two-stage chain.
      ks_meta <= bus.keypad;
      ks      <= ks_meta;
    end
  end

  // Next-state, debounce counter and captured key.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    key_next   = key_reg;
    case (state)
      IDLE: begin
        if (bus.accept && single_key) begin
          key_next   = ks;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (bus.accept && (ks == key_reg)) begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = LOAD;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      LOAD: begin
        // The strobe always completes once issued, whatever accept does.
        cnt_next   = '0;
        state_next = RELEASE;
      end
      RELEASE: begin
        if (ks == 10'd0) begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          // Any key seen restarts the release window; no second strobe.
          cnt_next = '0;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered busy/loadn and the digit latched on LOAD entry.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      cnt     <= '0;
      key_reg <= 10'd0;
      busy_q  <= 1'b0;
      loadn_q <= 1'b1;
      data_q  <= 4'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      key_reg <= key_next;
      busy_q  <= (state_next != IDLE);
      loadn_q <= (state_next != LOAD);
      if ((state == DEBOUNCE) && (state_next == LOAD)) begin
        data_q <= encode(key_reg);
      end
    end
  end

  // Digit counter: clear has priority over the LOAD increment; saturates at 3.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      digit_count_q <= 2'd0;
    end else if (bus.clr_entry) begin
      digit_count_q <= 2'd0;
    end else if ((state == LOAD) && (digit_count_q != 2'd3)) begin
      digit_count_q <= digit_count_q + 2'd1;
    end
  end

  assign bus.data        = data_q;
  assign bus.loadn       = loadn_q;
  assign bus.busy        = busy_q;
  assign bus.digit_count = digit_count_q;

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Directed testbench for keypad_digit_loader with DEBOUNCE_CYCLES = 4.
// A key driven just after edge C is first sampled at edge R = C+1, so LOAD
// (loadn low) begins at edge C+1+2+4 = C+7 and ends at edge C+8.
module tb_keypad_digit_loader;

  localparam int N = 4;

  logic clk;
  logic clrn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  keypad_digit_loader_if bus ();

  keypad_digit_loader #(.DEBOUNCE_CYCLES(N), .CNT_W(20)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records the digit and the edge at which each low pulse began.
  logic [3:0] strobe_data[$];
  int         strobe_edge[$];
  int         wide_pulses = 0;
  logic       prev_low = 1'b0;

  always @(negedge clk) begin
    if (bus.loadn === 1'b0) begin
      strobe_data.push_back(bus.data);
      strobe_edge.push_back(cyc);
      if (prev_low) wide_pulses++;
    end
    prev_low = (bus.loadn === 1'b0);
  end

  function automatic logic [9:0] key_bit(input int k);
    logic [9:0] one;
    one = 10'd1;
    return one << k;
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  task automatic clear_log();
    strobe_data.delete();
    strobe_edge.delete();
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #1;
    checks++;
    if (bus.loadn !== 1'b1) begin
      failures++; $display("FAIL reset_loadn got=%b exp=1", bus.loadn);
    end
    checks++;
    if (bus.data !== 4'd0) begin
      failures++; $display("FAIL reset_data got=%0d exp=0", bus.data);
    end
    checks++;
    if (bus.digit_count !== 2'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", bus.digit_count);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    tick(3);
    clrn = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press();
    int c;
    clear_log();
    bus.keypad = key_bit(7);
    c = cyc;
    wait_until(c + 6);
    checks++;
    if (bus.loadn !== 1'b1) begin
      failures++; $display("FAIL clean_early_loadn got=%b exp=1", bus.loadn);
    end
    tick();
    checks++;
    if (bus.loadn !== 1'b0 || bus.data !== 4'd7 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_load got loadn=%b data=%0d busy=%b exp loadn=0 data=7 busy=1",
               bus.loadn, bus.data, bus.busy);
    end
    tick();
    checks++;
    if (bus.loadn !== 1'b1 || bus.digit_count !== 2'd1) begin
      failures++;
      $display("FAIL clean_after got loadn=%b count=%0d exp loadn=1 count=1",
               bus.loadn, bus.digit_count);
    end
    wait_until(c + 20);
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (bus.busy !== 1'b0 || bus.data !== 4'd7) begin
      failures++; $display("FAIL clean_idle got busy=%b data=%0d exp busy=0 data=7", bus.busy, bus.data);
    end
    checks++;
    if (strobe_edge.size() != 1 || strobe_edge[0] != c + 7) begin
      failures++;
      $display("FAIL clean_strobes got n=%0d first_edge=%0d exp n=1 edge=%0d",
               strobe_edge.size(), (strobe_edge.size() > 0) ? strobe_edge[0] : -1, c + 7);
    end
  endtask

  task automatic test_bounce();
    int c;
    clear_log();
    bus.keypad = key_bit(3);
    tick(2);
    bus.keypad = 10'd0;
    tick(1);
    bus.keypad = key_bit(3);
    c = cyc;
    wait_until(c + 20);
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (strobe_edge.size() != 1 || strobe_edge[0] != c + 7 || strobe_data[0] !== 4'd3) begin
      failures++;
      $display("FAIL bounce_strobe got n=%0d edge=%0d data=%0d exp n=1 edge=%0d data=3",
               strobe_edge.size(), (strobe_edge.size() > 0) ? strobe_edge[0] : -1,
               (strobe_data.size() > 0) ? strobe_data[0] : 4'd15, c + 7);
    end
    checks++;
    if (bus.digit_count !== 2'd2) begin
      failures++; $display("FAIL bounce_count got=%0d exp=2", bus.digit_count);
    end
  endtask

  task automatic test_two_keys();
    int c;
    clear_log();
    bus.keypad = key_bit(2) | key_bit(5);
    tick(20);
    checks++;
    if (strobe_edge.size() != 0 || bus.busy !== 1'b0 || bus.digit_count !== 2'd2) begin
      failures++;
      $display("FAIL two_keys_held got n=%0d busy=%b count=%0d exp n=0 busy=0 count=2",
               strobe_edge.size(), bus.busy, bus.digit_count);
    end
    bus.keypad = key_bit(2);
    c = cyc;
    wait_until(c + 20);
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (strobe_edge.size() != 1 || strobe_edge[0] != c + 7 || strobe_data[0] !== 4'd2) begin
      failures++;
      $display("FAIL two_keys_release got n=%0d edge=%0d data=%0d exp n=1 edge=%0d data=2",
               strobe_edge.size(), (strobe_edge.size() > 0) ? strobe_edge[0] : -1,
               (strobe_data.size() > 0) ? strobe_data[0] : 4'd15, c + 7);
    end
    checks++;
    if (bus.digit_count !== 2'd3) begin
      failures++; $display("FAIL two_keys_count got=%0d exp=3", bus.digit_count);
    end
  endtask

  task automatic test_sequence();
    int         keys[4]   = '{1, 2, 0, 9};
    logic [1:0] counts[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    bus.clr_entry = 1'b1;
    tick();
    bus.clr_entry = 1'b0;
    checks++;
    if (bus.digit_count !== 2'd0) begin
      failures++; $display("FAIL seq_clear got=%0d exp=0", bus.digit_count);
    end
    clear_log();
    for (int i = 0; i < 4; i++) begin
      bus.keypad = key_bit(keys[i]);
      tick(20);
      bus.keypad = 10'd0;
      tick(20);
      checks++;
      if (bus.digit_count !== counts[i]) begin
        failures++; $display("FAIL seq_count%0d got=%0d exp=%0d", i, bus.digit_count, counts[i]);
      end
    end
    checks++;
    if (strobe_data.size() != 4) begin
      failures++; $display("FAIL seq_strobes got=%0d exp=4", strobe_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (strobe_data[i] !== 4'(keys[i])) begin
          failures++; $display("FAIL seq_data%0d got=%0d exp=%0d", i, strobe_data[i], keys[i]);
        end
      end
    end
  endtask

  task automatic test_accept();
    int c;
    bus.clr_entry = 1'b1;
    tick();
    bus.clr_entry = 1'b0;
    clear_log();
    bus.accept = 1'b0;
    bus.keypad = key_bit(4);
    tick(20);
    checks++;
    if (strobe_edge.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL accept_low got n=%0d busy=%b exp n=0 busy=0", strobe_edge.size(), bus.busy);
    end
    bus.keypad = 10'd0;
    tick(5);
    bus.accept = 1'b1;
    bus.keypad = key_bit(4);
    c = cyc;
    wait_until(c + 7);
    checks++;
    if (bus.loadn !== 1'b0) begin
      failures++; $display("FAIL accept_load got loadn=%b exp=0", bus.loadn);
    end
    bus.accept = 1'b0;
    tick();
    checks++;
    if (bus.loadn !== 1'b1 || bus.busy !== 1'b1 || bus.digit_count !== 2'd1) begin
      failures++;
      $display("FAIL accept_drop got loadn=%b busy=%b count=%0d exp loadn=1 busy=1 count=1",
               bus.loadn, bus.busy, bus.digit_count);
    end
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (strobe_data.size() != 1 || strobe_data[0] !== 4'd4 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL accept_done got n=%0d data=%0d busy=%b exp n=1 data=4 busy=0",
               strobe_data.size(), (strobe_data.size() > 0) ? strobe_data[0] : 4'd15, bus.busy);
    end
    bus.accept = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c;
    clear_log();
    bus.keypad = key_bit(5);
    c = cyc;
    wait_until(c + 4);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL midrst_debounce got busy=%b exp=1", bus.busy);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.loadn !== 1'b1 || bus.digit_count !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async got busy=%b loadn=%b count=%0d exp busy=0 loadn=1 count=0",
               bus.busy, bus.loadn, bus.digit_count);
    end
    bus.keypad = 10'd0;
    tick(2);
    clrn = 1'b1;
    tick(20);
    checks++;
    if (strobe_edge.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got n=%0d busy=%b exp n=0 busy=0", strobe_edge.size(), bus.busy);
    end
  endtask

  task automatic test_clr_coincident();
    int c;
    bus.keypad = key_bit(6);
    tick(20);
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (bus.digit_count !== 2'd1) begin
      failures++; $display("FAIL clrco_pre got=%0d exp=1", bus.digit_count);
    end
    clear_log();
    bus.keypad = key_bit(8);
    c = cyc;
    wait_until(c + 7);
    bus.clr_entry = 1'b1;
    tick();
    bus.clr_entry = 1'b0;
    checks++;
    if (bus.digit_count !== 2'd0 || bus.data !== 4'd8 || bus.loadn !== 1'b1) begin
      failures++;
      $display("FAIL clrco_edge got count=%0d data=%0d loadn=%b exp count=0 data=8 loadn=1",
               bus.digit_count, bus.data, bus.loadn);
    end
    bus.keypad = 10'd0;
    tick(20);
    checks++;
    if (strobe_data.size() != 1 || bus.digit_count !== 2'd0) begin
      failures++;
      $display("FAIL clrco_after got n=%0d count=%0d exp n=1 count=0",
               strobe_data.size(), bus.digit_count);
    end
  endtask

  initial begin
    clrn          = 1'b1;
    bus.keypad    = 10'd0;
    bus.accept    = 1'b1;
    bus.clr_entry = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_sequence();
    test_accept();
    test_reset_mid();
    test_clr_coincident();
    checks++;
    if (wide_pulses != 0) begin
      failures++; $display("FAIL strobe_width got wide=%0d exp=0", wide_pulses);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
